alu_pipe: RTL and testbench

Parametrised, handshaked successor to the team's fixed 32-bit registered ALU. Accepts one operation per transfer on a valid/ready input channel and returns a registered result, a status-flag vector and a pass-through tag on a valid/ready output channel. Adds signed compares, arithmetic shift right, and an optional iterative multiplier. Sits between the datapath register-read stage and writeback, so it tolerates output backpressure.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_pipe_if.sv | 33 +++
 rtl/alu_mul_seq.sv | 45 ++++
 rtl/alu_pipe.sv | 165 ++++++++++++++++
 tb/tb_alu_pipe.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for alu_pipe: opcodes, flag bit positions and controller states.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLL  = 4'h4;
  localparam logic [3:0] OP_SRL  = 4'h5;
  localparam logic [3:0] OP_XNOR = 4'h6;
  localparam logic [3:0] OP_EQ   = 4'h7;
  localparam logic [3:0] OP_LTU  = 4'h8;
  localparam logic [3:0] OP_GTU  = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_SRA  = 4'hB;
  localparam logic [3:0] OP_LTS  = 4'hC;
  localparam logic [3:0] OP_GTS  = 4'hD;
  localparam logic [3:0] OP_MUL  = 4'hE;
  localparam logic [3:0] OP_RSVD = 4'hF;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 3;
  localparam int FLAG_ILL   = 4;
  localparam int FLAG_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Operation/result channel of alu_pipe: valid/ready in, valid/ready out.
// master = producer of operations and consumer of results; slave = the ALU.
interface alu_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       Op;
  logic [SHW-1:0]   shift;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Out;
  logic [4:0]       flags;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, A, B, Op, shift, in_tag, out_ready,
    input  in_ready, out_valid, Out, flags, out_tag
  );

  modport slave (
    input  in_valid, A, B, Op, shift, in_tag, out_ready,
    output in_ready, out_valid, Out, flags, out_tag
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier returning the low WIDTH bits of a*b.
// Latency: WIDTH steps after start; done flags the cycle of the final step. No backpressure: product holds until next start.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      cnt    <= CW'(WIDTH);
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

  assign busy    = (cnt != '0);
  assign done    = (cnt == CW'(1));
  assign product = acc;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result/flags/tag; multiplier present only when ALU_MUL_EN is defined.
// Latency: result registered at the accepting edge (1 cycle); MUL writes WIDTH+1 edges after accept.
// Backpressure: result held while out_ready low; in_ready only when IDLE and the output slot frees.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input logic       clk,
  input logic       reset,
  alu_pipe_if.slave bus
);
  state_t           state;
  logic             out_valid;
  logic [WIDTH-1:0] out_q;
  logic [4:0]       flags_q;
  logic [TAG_W-1:0] tag_q;

  logic             out_free;
  logic             accept;
  logic [WIDTH-1:0] res;
  logic [4:0]       res_flags;
  logic             res_carry;
  logic             res_ovf;
  logic             res_ill;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   dif_ext;
  logic             add_ovf;
  logic             sub_ovf;

  function automatic logic [WIDTH-1:0] bool_w(input logic b);
    return {{(WIDTH-1){1'b0}}, b};
  endfunction

  function automatic logic [4:0] pack_flags(input logic [WIDTH-1:0] r, input logic c,
                                            input logic v, input logic il);
    logic [4:0] f;
    f             = '0;
    f[FLAG_ZERO]  = (r == '0);
    f[FLAG_NEG]   = r[WIDTH-1];
    f[FLAG_CARRY] = c;
    f[FLAG_OVF]   = v;
    f[FLAG_ILL]   = il;
    return f;
  endfunction

  assign out_free     = !out_valid || bus.out_ready;
  assign bus.in_ready = (state == IDLE) && out_free;
  assign accept       = bus.in_valid && bus.in_ready;

  // The extra top bit is carry-out for ADD and borrow (A < B unsigned) for SUB.
  assign sum_ext = {1'b0, bus.A} + {1'b0, bus.B};
  assign dif_ext = {1'b0, bus.A} - {1'b0, bus.B};
  assign add_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_ext[WIDTH-1] != bus.A[WIDTH-1]);
  assign sub_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (dif_ext[WIDTH-1] != bus.A[WIDTH-1]);

  always_comb begin
    res       = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    res_ill   = 1'b0;
    case (bus.Op)
      OP_ADD: begin
        res       = sum_ext[WIDTH-1:0];
        res_carry = sum_ext[WIDTH];
        res_ovf   = add_ovf;
      end
      OP_SUB: begin
        res       = dif_ext[WIDTH-1:0];
        res_carry = dif_ext[WIDTH];
        res_ovf   = sub_ovf;
      end
      OP_AND:  res = bus.A & bus.B;
      OP_OR:   res = bus.A | bus.B;
      OP_SLL:  res = bus.A << bus.shift;
      OP_SRL:  res = bus.A >> bus.shift;
      OP_XNOR: res = ~(bus.A ^ bus.B);
      OP_EQ:   res = bool_w(bus.A == bus.B);
      OP_LTU:  res = bool_w(bus.A < bus.B);
      OP_GTU:  res = bool_w(bus.A > bus.B);
      OP_XOR:  res = bus.A ^ bus.B;
      OP_SRA:  res = $signed(bus.A) >>> bus.shift;
      OP_LTS:  res = bool_w($signed(bus.A) < $signed(bus.B));
      OP_GTS:  res = bool_w($signed(bus.A) > $signed(bus.B));
      // Reserved op, and MUL when it is not diverted to the multiplier.
      default: res_ill = 1'b1;
    endcase
    res_flags = pack_flags(res, res_carry, res_ovf, res_ill);
  end

`ifdef ALU_MUL_EN
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;
  logic [TAG_W-1:0] mul_tag;

  assign mul_start = accept && (bus.Op == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (bus.A),
    .b       (bus.B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_q     <= '0;
      flags_q   <= '0;
      tag_q     <= '0;
`ifdef ALU_MUL_EN
      mul_tag   <= '0;
`endif
    end else begin
      // A write below overrides this clear, giving back-to-back streaming.
      if (out_valid && bus.out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
`ifdef ALU_MUL_EN
          if (mul_start) begin
            state   <= MUL;
            mul_tag <= bus.in_tag;
          end else
`endif
          if (accept) begin
            out_valid <= 1'b1;
            out_q     <= res;
            flags_q   <= res_flags;
            tag_q     <= bus.in_tag;
          end
        end
`ifdef ALU_MUL_EN
        MUL: begin
          if (mul_done) state <= WAIT;
        end
        WAIT: begin
          if (!mul_busy && out_free) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            out_q     <= mul_prod;
            flags_q   <= pack_flags(mul_prod, 1'b0, 1'b0, 1'b0);
            tag_q     <= mul_tag;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.Out       = out_q;
  assign bus.flags     = flags_q;
  assign bus.out_tag   = tag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors plus randomized ops checked against a reference model.
module tb_alu_pipe;
  import alu_pkg::*;

`ifdef ALU_MUL_EN
  localparam logic [31:0] MUL_EXP_OUT = 32'h01234500;
  localparam logic [4:0]  MUL_EXP_FLG = 5'b00000;
  localparam int          MUL_EDGES   = 33;
`else
  localparam logic [31:0] MUL_EXP_OUT = 32'h00000000;
  localparam logic [4:0]  MUL_EXP_FLG = 5'b10001;
  localparam int          MUL_EDGES   = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(32), .TAG_W(4)) bus ();
  alu_pipe #(.WIDTH(32), .TAG_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] out;
    logic [4:0]  flags;
    logic [3:0]  tag;
  } exp_t;

  exp_t scb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   acc_edge = 0;
  int   n_pop    = 0;
  bit   rand_rdy = 1'b0;
  bit   rdy_force = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Sole driver of out_ready: random when enabled, else the level the stimulus asks for.
  always @(posedge clk) begin
    #2;
    bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values; returns {illegal,ovf,carry,neg,zero,out}.
  function automatic logic [36:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op, input logic [4:0] sh);
    longint ua, ub, sa, sb, t;
    logic [31:0] r;
    logic c, v, il;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'd0; c = 1'b0; v = 1'b0; il = 1'b0;
    case (op)
      OP_ADD: begin
        t = ua + ub; r = t[31:0]; c = (ua + ub) > 64'sd4294967295;
        t = sa + sb; v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      OP_SUB: begin
        t = ua - ub; r = t[31:0]; c = (ua < ub);
        t = sa - sb; v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLL:  begin t = ua << sh; r = t[31:0]; end
      OP_SRL:  r = a >> sh;
      OP_XNOR: r = ~(a ^ b);
      OP_EQ:   r = (ua == ub) ? 32'd1 : 32'd0;
      OP_LTU:  r = (ua <  ub) ? 32'd1 : 32'd0;
      OP_GTU:  r = (ua >  ub) ? 32'd1 : 32'd0;
      OP_XOR:  r = a ^ b;
      OP_SRA:  begin t = sa >>> sh; r = t[31:0]; end
      OP_LTS:  r = (sa < sb) ? 32'd1 : 32'd0;
      OP_GTS:  r = (sa > sb) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
      OP_MUL:  begin t = ua * ub; r = t[31:0]; end
`endif
      default: il = 1'b1;
    endcase
    return {il, v, c, r[31], (r == 32'd0), r};
  endfunction

  // Monitor: every cycle a result is presented it must match the oldest outstanding op.
  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      if (scb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got tag %0h with no outstanding op", bus.out_tag);
      end else begin
        check("out",   64'(bus.Out),     64'(scb[0].out));
        check("flags", 64'(bus.flags),   64'(scb[0].flags));
        check("tag",   64'(bus.out_tag), 64'(scb[0].tag));
        if (bus.out_ready) begin
          void'(scb.pop_front());
          n_pop++;
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                      input logic [4:0] sh, input logic [3:0] tag,
                      input logic [31:0] eo, input logic [4:0] ef);
    bit done = 1'b0;
    int n = 0;
    bus.A = a; bus.B = b; bus.Op = op; bus.shift = sh; bus.in_tag = tag;
    bus.in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        scb.push_back('{eo, ef, tag});
        acc_edge = cyc + 1;
        done = 1'b1;
      end else if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_ready=%b expected 1 within 300 cycles", bus.in_ready);
        done = 1'b1;
      end
      n++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input logic [4:0] sh, input logic [3:0] tag);
    logic [36:0] r;
    r = ref_alu(a, b, op, sh);
    send(a, b, op, sh, tag, r[31:0], r[36:32]);
  endtask

  // Edge offset from the accepting edge to the edge that raised out_valid; also whether in_ready stayed low meanwhile.
  task automatic wait_out(output int lat, output bit rdy_low);
    int n = 0;
    lat = -1;
    rdy_low = 1'b1;
    while (lat < 0 && n < 200) begin
      @(negedge clk);
      if (bus.out_valid) lat = cyc - acc_edge;
      else if (bus.in_ready) rdy_low = 1'b0;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    rand_rdy = 1'b0;
    rdy_force = 1'b1;
    while (scb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (scb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d outstanding results expected 0", scb.size());
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h00000000;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    bit rl;
    int c0, p0;

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.Op = '0; bus.shift = '0; bus.in_tag = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out",       64'(bus.Out),       64'd0);
    check("rst_flags",     64'(bus.flags),     64'd0);
    check("rst_tag",       64'(bus.out_tag),   64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);

    rdy_force = 1'b1;
    @(posedge clk); #1;

    send(32'hFFFFFFFF, 32'h1, OP_ADD, 5'd0, 4'h1, 32'h00000000, 5'b00101);
    wait_out(lat, rl);
    check("add_result_edge", 64'(lat), 64'd0);
    send(32'h7FFFFFFF, 32'h1, OP_ADD, 5'd0, 4'h2, 32'h80000000, 5'b01010);
    send(32'hFFFFFFFE, 32'h2, OP_LTU, 5'd0, 4'h3, 32'h00000000, 5'b00001);
    send(32'hFFFFFFFE, 32'h2, OP_LTS, 5'd0, 4'h4, 32'h00000001, 5'b00000);
    send(32'h80000000, 32'h0, OP_SRA, 5'd4, 4'h5, 32'hF8000000, 5'b00010);
    send(32'h80000000, 32'h0, OP_SRL, 5'd4, 4'h6, 32'h08000000, 5'b00000);
    drain();

    p0 = n_pop;
    c0 = cyc;
    for (int t = 0; t < 8; t++) send_m($urandom, $urandom, OP_ADD, 5'd0, 4'(t));
    check("stream_accept_edges", 64'(cyc - c0), 64'd8);
    @(negedge clk);
    @(posedge clk); #1;
    check("stream_results", 64'(n_pop - p0), 64'd8);

    drain();
    rdy_force = 1'b0;
    @(posedge clk); #1;
    send_m(32'h12345678, 32'h0000FFFF, OP_SUB, 5'd0, 4'hA);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
    end
    rdy_force = 1'b1;
    c0 = cyc;
    send_m(32'hA5A5A5A5, 32'h0F0F0F0F, OP_XOR, 5'd0, 4'hB);
    check("bp_accept_same_cycle", 64'(cyc - c0), 64'd1);

    drain();
    send(32'h00012345, 32'h00000100, OP_MUL, 5'd0, 4'h5, MUL_EXP_OUT, MUL_EXP_FLG);
    wait_out(lat, rl);
    check("mul_result_edge", 64'(lat), 64'(MUL_EDGES));
    check("mul_in_ready_low", 64'(rl), 64'd1);

    drain();
    rdy_force = 1'b0;
    send(32'h00012345, 32'h00000100, OP_MUL, 5'd0, 4'h9, MUL_EXP_OUT, MUL_EXP_FLG);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    scb.delete();
    reset = 1'b0;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out",       64'(bus.Out),       64'd0);
    check("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    rdy_force = 1'b1;
    send(32'd3, 32'd4, OP_ADD, 5'd0, 4'h7, 32'd7, 5'b00000);
    wait_out(lat, rl);
    check("post_rst_add_edge", 64'(lat), 64'd0);

    drain();
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_m(pick(), pick(), 4'($urandom_range(0, 15)), 5'($urandom), 4'($urandom));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    drain();
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
